// File: rtl/coffee_status_encoder.sv
// -----------------------------------------------------------------------------
// coffee_status_encoder
//
// Front-end controller for the coffee machine. It converts the raw drink
// buttons, the three ingredient sensors and the payment result into one-hot
// message-select lines for the 7-segment message decoder. The decoder ORs the
// segment patterns of every active select, so exactly one select is high in
// every cycle, including during reset.
//
// Ports
//   CLK        in   system clock, all state on the rising edge
//   RST_N      in   asynchronous active-low reset
//   BTN[3:0]   in   raw drink buttons, asynchronous to CLK, bit i = drink Si
//   SR_OK      in   water reservoir ok (synchronous level)
//   SP_OK      in   powder ok (synchronous level)
//   SN_OK      in   level sensor ok (synchronous level)
//   PAY_STB    in   one-cycle strobe, payment evaluation complete
//   PAY_OK     in   payment result, qualified by PAY_STB
//   S0..S3     out  drink message selects
//   SR,SP,SN   out  sensor error message selects
//   VL         out  payment error message select
//   M          out  standby message select
//   BUSY       out  high while an order is selected or dispensing
//   STATE_DBG  out  current order FSM state (observation only)
//
// Handshake: there is no valid/ready pair on this block. PAY_STB is a
// single-cycle qualifier; PAY_OK is meaningful only in a cycle where PAY_STB
// is high and is otherwise ignored. There is no back-pressure.
// -----------------------------------------------------------------------------
module coffee_status_encoder #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned ERR_HOLD    = 64,
  parameter int unsigned SEL_TIMEOUT = 256,
  parameter int unsigned DISP_CYCLES = 128
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       SR_OK,
  input  logic       SP_OK,
  input  logic       SN_OK,
  input  logic       PAY_STB,
  input  logic       PAY_OK,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       SR,
  output logic       SP,
  output logic       SN,
  output logic       VL,
  output logic       M,
  output logic       BUSY,
  output logic [1:0] STATE_DBG
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Error source codes; also the bit offset within the error select group.
  localparam logic [1:0] ERR_SR = 2'd0;
  localparam logic [1:0] ERR_SP = 2'd1;
  localparam logic [1:0] ERR_SN = 2'd2;
  localparam logic [1:0] ERR_VL = 2'd3;

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  localparam int unsigned T_MAX1 = (SEL_TIMEOUT > DISP_CYCLES) ? SEL_TIMEOUT : DISP_CYCLES;
  localparam int unsigned T_MAX  = (T_MAX1 > ERR_HOLD) ? T_MAX1 : ERR_HOLD;
  localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(T_MAX);
  localparam logic [TMR_W-1:0] SEL_LAST  = TMR_W'(SEL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DISP_LAST = TMR_W'(DISP_CYCLES - 1);
  localparam logic [TMR_W-1:0] ERR_LAST  = TMR_W'(ERR_HOLD - 1);

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchroniser, saturating stability counter, and a
  // registered one-cycle press pulse raised on the cycle the counter reaches
  // DEB_CYCLES. Because the counter then sits at DEB_CYCLES, the pulse cannot
  // repeat until a sampled 0 clears it. Raw edge to select change is
  // DEB_CYCLES+3 edges: 2 sync + DEB_CYCLES-1 counting + pulse + FSM.
  // ---------------------------------------------------------------------------
  logic [3:0]       sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q [4];
  logic [3:0]       press_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        press_q[i] <= sync2_q[i] && (deb_cnt_q[i] == DEB_LAST);
        if (!sync2_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] != DEB_MAX) begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Lowest-index press wins; simultaneous higher presses are dropped.
  logic       press_any;
  logic [1:0] press_idx;

  always_comb begin
    press_any = |press_q;
    press_idx = 2'd0;
    if (press_q[0])      press_idx = 2'd0;
    else if (press_q[1]) press_idx = 2'd1;
    else if (press_q[2]) press_idx = 2'd2;
    else if (press_q[3]) press_idx = 2'd3;
  end

  // Sensor fault priority: reservoir, then powder, then level.
  logic       fault;
  logic [1:0] fault_code;

  always_comb begin
    fault      = 1'b1;
    fault_code = ERR_SR;
    if (!SR_OK)      fault_code = ERR_SR;
    else if (!SP_OK) fault_code = ERR_SP;
    else if (!SN_OK) fault_code = ERR_SN;
    else             fault      = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Order FSM. One shared timer serves all timed states; it restarts on every
  // state entry and on a re-selection, and saturates instead of wrapping.
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       drink_q, drink_d;
  logic [1:0]       err_q, err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [8:0]       sel_q, sel_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      drink_q <= 2'd0;
      err_q   <= ERR_SR;
      tmr_q   <= '0;
      sel_q   <= 9'b1_0000_0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drink_q <= drink_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drink_d = drink_q;
    err_d   = err_q;
    tmr_d   = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (press_any) begin
          if (fault) begin
            state_d = ST_ERROR;
            err_d   = fault_code;
          end else begin
            state_d = ST_SELECTED;
            drink_d = press_idx;
          end
        end
      end
      ST_SELECTED: begin
        // A payment result outranks a same-cycle press.
        if (PAY_STB) begin
          if (fault) begin
            state_d = ST_ERROR;
            err_d   = fault_code;
          end else if (PAY_OK) begin
            state_d = ST_DISPENSE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_VL;
          end
        end else if (press_any) begin
          drink_d = press_idx;
          tmr_d   = '0;
        end else if (tmr_q == SEL_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (fault) begin
          state_d = ST_ERROR;
          err_d   = fault_code;
        end else if (tmr_q == DISP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (tmr_q == ERR_LAST) state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) tmr_d = '0;
  end

  // Selects are derived from the next state so they register together with it.
  always_comb begin
    sel_d  = '0;
    busy_d = 1'b0;
    unique case (state_d)
      ST_IDLE:     sel_d[8] = 1'b1;
      ST_SELECTED,
      ST_DISPENSE: begin
        sel_d[3:0] = 4'b0001 << drink_d;
        busy_d     = 1'b1;
      end
      ST_ERROR:    sel_d[7:4] = 4'b0001 << err_d;
    endcase
  end

  assign {M, VL, SN, SP, SR, S3, S2, S1, S0} = sel_q;
  assign BUSY      = busy_q;
  assign STATE_DBG = state_q;

endmodule

// File: doc/coffee_status_encoder.md
Name: coffee_status_encoder

Overview:
- Front-end controller for the coffee machine. Turns raw drink buttons, ingredient sensors and the payment result into the one-hot message-select lines consumed by the 7-segment message decoder.
- Selects: S0..S3 (drink), SR/SP/SN (sensor errors), VL (payment error), M (standby).
- Debounces buttons, runs the order state machine and holds error messages for a fixed time.
- Guarantees exactly one select line is high in every cycle, because the decoder ORs all message segments.

Parameters:
- DEB_CYCLES, 16: consecutive stable-high cycles (after the synchroniser) needed to accept a button press.
- ERR_HOLD, 64: cycles an error message is displayed before returning to standby.
- SEL_TIMEOUT, 256: cycles allowed in SELECTED with no payment before abandoning the order.
- DISP_CYCLES, 128: cycles the drink message is held while dispensing.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- BTN  in  4  raw drink buttons, active-high, asynchronous to CLK; bit i selects drink Si
- SR_OK  in  1  water reservoir sensor, 1 = ok (synchronous level)
- SP_OK  in  1  powder sensor, 1 = ok
- SN_OK  in  1  level sensor, 1 = ok
- PAY_STB  in  1  one-cycle strobe: payment evaluation complete
- PAY_OK  in  1  payment result, sampled only when PAY_STB=1
- S0, S1, S2, S3  out  1 each  drink message select
- SR, SP, SN  out  1 each  sensor error message select
- VL  out  1  payment error message select
- M  out  1  standby message select
- BUSY  out  1  high in SELECTED and DISPENSE

Behaviour:
- **Reset:** asynchronous on RST_N=0.
  - State = IDLE; M=1; all other selects 0; BUSY=0.
  - All counters and synchronisers cleared.
  - Reset mid-operation aborts any order with no residual state.
- **Select outputs:** all registered; one-hot invariant holds every cycle.
- **Button input path:**
  - Each BTN bit passes through a 2-flop synchroniser, then a saturating stability counter.
  - Any sampled 0 clears the counter.
  - A press event fires for one cycle when the counter reaches DEB_CYCLES. No re-fire until the button is released and debounced again.
  - Several press events in the same cycle: lowest index wins; the others are discarded.
- **Latency:** raw BTN held high → select change after exactly DEB_CYCLES+3 rising edges.
- **Error priority:** SR_OK=0 beats SP_OK=0, which beats SN_OK=0, which beats the payment error.
- **State IDLE** (M=1):
  - Press i with all sensors ok → SELECTED with drink i; Si=1; selection timer cleared.
  - Press with any sensor fault → ERROR showing the highest-priority fault.
  - PAY_STB is ignored.
- **State SELECTED** (Si=1, BUSY=1):
  - New press j → Si cleared, Sj set, timer cleared.
  - PAY_STB=1, PAY_OK=1, all sensors ok → DISPENSE; Si stays high.
  - PAY_STB=1, PAY_OK=0 → ERROR showing VL.
  - PAY_STB=1 with a sensor fault → ERROR showing the sensor fault, whatever PAY_OK is.
  - Timer reaches SEL_TIMEOUT → IDLE.
  - Same-cycle press and PAY_STB: PAY_STB wins; the press is discarded.
- **State DISPENSE** (Si=1, BUSY=1):
  - Counts DISP_CYCLES, then → IDLE.
  - Any sensor going 0 → ERROR with that fault in the next cycle (priority applies).
  - Presses and PAY_STB are ignored.
- **State ERROR** (exactly one of SR/SP/SN/VL high):
  - Error source is latched on entry.
  - Holds ERR_HOLD cycles, then → IDLE.
  - Inputs are ignored, including new faults.
  - A sensor still faulty on return does not re-enter ERROR until the next press.
- **Counters:** timers are sized ceil(log2(max+1)) bits, never wrap, and clear on every state entry.

Test Plan (bench parameters DEB_CYCLES=4, ERR_HOLD=8, SEL_TIMEOUT=20, DISP_CYCLES=10):
1. **Reset:** RST_N=0 asynchronously mid-DISPENSE → M=1, others 0, BUSY=0 immediately without a clock edge; stays so after release with no input.
2. **Debounce:** BTN[2] pulsed high 3 cycles → no change. Then held high → S2=1 exactly 7 edges after the rise, M=0, BUSY=1.
3. **Full order:** BTN[1] press, then PAY_STB=1 with PAY_OK=1 → S1 held 10 cycles total in DISPENSE, then M=1.
4. **Payment reject:** in SELECTED S3, PAY_STB=1 with PAY_OK=0 → VL=1 for 8 cycles, then M=1.
5. **Sensor priority:** SR_OK=0 and SN_OK=0, press BTN[0] → SR=1 only, for 8 cycles, then M=1. Drop SP_OK mid-DISPENSE → SP=1 next cycle.
6. **Collision and timeout:**
   - BTN[3] and BTN[1] debounced together → S1=1.
   - No payment → M=1 after 20 cycles.
   - Every cycle of the run: exactly one select high.
